// File: rtl/render_pkg.sv
// Shared widths, reserved ids, register map and FSM state type for the
// rect renderer chain head.
package render_pkg;

    localparam int X_W    = 11;
    localparam int Y_W    = 12;
    localparam int DATA_W = 32;
    localparam int CMD_W  = X_W + Y_W + DATA_W;

    // Shape 2047 never matches a real renderer, so beats carrying it pass
    // through the whole chain untouched.
    localparam logic [X_W-1:0] NULL_SHAPE_ID = 11'h7FF;

    localparam logic [Y_W-1:0] REG_XCOORD = 12'd0;
    localparam logic [Y_W-1:0] REG_YCOORD = 12'd1;
    localparam logic [Y_W-1:0] REG_WIDTH  = 12'd2;
    localparam logic [Y_W-1:0] REG_HEIGHT = 12'd3;
    localparam logic [Y_W-1:0] REG_COLOR  = 12'd4;

    typedef enum logic [1:0] {
        IDLE,
        PROG,
        SCAN
    } state_t;

    typedef struct packed {
        logic [X_W-1:0]    shape_id;
        logic [Y_W-1:0]    reg_id;
        logic [DATA_W-1:0] data;
    } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO holding shape-register write commands until the
// driver is between frames. Pointers carry an extra wrap bit so full and
// empty are distinguished without a separate counter.
module cmd_fifo
    import render_pkg::*;
#(
    parameter int WIDTH = CMD_W,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Advance the read and write pointers; reset empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage array; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/render_chain_driver.sv
// Head of the rect renderer chain. Buffers register-write commands and
// emits one registered beat per cycle: write beats between frames,
// raster-scan pixel beats during a frame, and null beats otherwise.
module render_chain_driver
    import render_pkg::*;
#(
    parameter int          H_ACTIVE   = 1920,
    parameter int          V_ACTIVE   = 1080,
    parameter logic [31:0] BG_COLOR   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [X_W-1:0]    cmd_shape_id,
    input  logic [Y_W-1:0]    cmd_reg_id,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              program_out,
    output logic [X_W-1:0]    x_out,
    output logic [Y_W-1:0]    y_out,
    output logic [DATA_W-1:0] data_out,
    output logic              frame_done,
    output logic              busy
);

    localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

    state_t state;
    state_t state_next;

    logic [X_W-1:0] x_cnt;
    logic [X_W-1:0] x_next;
    logic [Y_W-1:0] y_cnt;
    logic [Y_W-1:0] y_next;

    logic              prog_n;
    logic [X_W-1:0]    x_out_n;
    logic [Y_W-1:0]    y_out_n;
    logic [DATA_W-1:0] data_n;
    logic              done_n;
    logic              emit_pixel;

    logic fifo_pop;
    logic fifo_full;
    logic fifo_empty;
    cmd_t fifo_in;
    cmd_t fifo_head;

    assign fifo_in   = '{shape_id: cmd_shape_id, reg_id: cmd_reg_id, data: cmd_data};
    assign cmd_ready = !fifo_full;
    assign busy      = (state != IDLE);

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // State and raster counters; counters are always zero while idle so a
    // new frame can start from them directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            state <= state_next;
            x_cnt <= x_next;
            y_cnt <= y_next;
        end
    end

    // Choose the next beat, FIFO pop and next state; commands win over frames.
    always_comb begin
        state_next = state;
        x_next     = x_cnt;
        y_next     = y_cnt;
        fifo_pop   = 1'b0;
        emit_pixel = 1'b0;
        prog_n     = 1'b1;
        x_out_n    = NULL_SHAPE_ID;
        y_out_n    = '0;
        data_n     = '0;
        done_n     = 1'b0;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    x_out_n    = fifo_head.shape_id;
                    y_out_n    = fifo_head.reg_id;
                    data_n     = fifo_head.data;
                    state_next = PROG;
                end else if (run) begin
                    emit_pixel = 1'b1;
                end
            end
            PROG: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    x_out_n  = fifo_head.shape_id;
                    y_out_n  = fifo_head.reg_id;
                    data_n   = fifo_head.data;
                end else begin
                    state_next = IDLE;
                end
            end
            SCAN: begin
                emit_pixel = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (emit_pixel) begin
            prog_n  = 1'b0;
            x_out_n = x_cnt;
            y_out_n = y_cnt;
            data_n  = BG_COLOR;
            if (x_cnt == X_LAST) begin
                x_next = '0;
                if (y_cnt == Y_LAST) begin
                    y_next     = '0;
                    done_n     = 1'b1;
                    state_next = IDLE;
                end else begin
                    y_next     = y_cnt + Y_W'(1);
                    state_next = SCAN;
                end
            end else begin
                x_next     = x_cnt + X_W'(1);
                state_next = SCAN;
            end
        end
    end

    // Register the stream outputs; reset forces a null beat immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            program_out <= 1'b1;
            x_out       <= NULL_SHAPE_ID;
            y_out       <= '0;
            data_out    <= '0;
            frame_done  <= 1'b0;
        end else begin
            program_out <= prog_n;
            x_out       <= x_out_n;
            y_out       <= y_out_n;
            data_out    <= data_n;
            frame_done  <= done_n;
        end
    end

endmodule

// File: tb/tb_render_chain_driver.sv
// Self-checking bench for render_chain_driver on a small 8x4 frame.
// A queue/pixel-index model predicts every beat; directed tests add
// hand-computed literal checks at the interesting points.
module tb_render_chain_driver;

    localparam int          H       = 8;
    localparam int          V       = 4;
    localparam int          NPIX    = H * V;
    localparam int          DEPTH   = 8;
    localparam logic [31:0] BG      = 32'hA5A5_0F0F;
    localparam logic [10:0] NULL_ID = 11'h7FF;

    typedef struct packed {
        logic        prog;
        logic [10:0] x;
        logic [11:0] y;
        logic [31:0] data;
        logic        fd;
    } beat_t;

    typedef struct {
        logic [10:0] shape;
        logic [11:0] rid;
        logic [31:0] data;
    } tb_cmd_t;

    logic        clk          = 1'b0;
    logic        rst          = 1'b0;
    logic        run          = 1'b0;
    logic        cmd_valid    = 1'b0;
    logic        cmd_ready;
    logic [10:0] cmd_shape_id = '0;
    logic [11:0] cmd_reg_id   = '0;
    logic [31:0] cmd_data     = '0;
    logic        program_out;
    logic [10:0] x_out;
    logic [11:0] y_out;
    logic [31:0] data_out;
    logic        frame_done;
    logic        busy;

    beat_t dut_beat;
    assign dut_beat = {program_out, x_out, y_out, data_out, frame_done};

    render_chain_driver #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .BG_COLOR   (BG),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_shape_id (cmd_shape_id),
        .cmd_reg_id   (cmd_reg_id),
        .cmd_data     (cmd_data),
        .program_out  (program_out),
        .x_out        (x_out),
        .y_out        (y_out),
        .data_out     (data_out),
        .frame_done   (frame_done),
        .busy         (busy)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic beat_t nullBeat();
        return beat_t'{1'b1, NULL_ID, 12'd0, 32'd0, 1'b0};
    endfunction

    task automatic checkBeat(input string name, input logic p, input logic [10:0] x,
                             input logic [11:0] y, input logic [31:0] d, input logic fd);
        checkOutput(name, 64'(dut_beat), 64'(beat_t'{p, x, y, d, fd}));
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [10:0] s,
                                 input logic [11:0] id, input logic [31:0] d);
        run          = r;
        cmd_valid    = v;
        cmd_shape_id = s;
        cmd_reg_id   = id;
        cmd_data     = d;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Behavioural model: accepted commands in a queue, frame as a linear pixel index.
    tb_cmd_t q[$];
    beat_t   exp_beat  = beat_t'{1'b1, 11'h7FF, 12'd0, 32'd0, 1'b0};
    bit      in_frame  = 1'b0;
    bit      draining  = 1'b0;
    int      pix       = 0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            q.delete();
            in_frame = 1'b0;
            draining = 1'b0;
            pix      = 0;
            exp_beat = nullBeat();
        end else begin
            bit      accept;
            tb_cmd_t c;
            accept = cmd_valid && (q.size() < DEPTH);
            if (in_frame) begin
                exp_beat = beat_t'{1'b0, 11'(pix % H), 12'(pix / H), BG, pix == NPIX - 1};
                if (pix == NPIX - 1) begin
                    in_frame = 1'b0;
                    pix      = 0;
                end else begin
                    pix++;
                end
            end else if (q.size() > 0) begin
                c        = q.pop_front();
                exp_beat = beat_t'{1'b1, c.shape, c.rid, c.data, 1'b0};
                draining = 1'b1;
            end else if (draining) begin
                exp_beat = nullBeat();
                draining = 1'b0;
            end else if (run) begin
                exp_beat = beat_t'{1'b0, 11'd0, 12'd0, BG, NPIX == 1};
                if (NPIX > 1) begin
                    in_frame = 1'b1;
                    pix      = 1;
                end
            end else begin
                exp_beat = nullBeat();
            end
            if (accept) begin
                c.shape = cmd_shape_id;
                c.rid   = cmd_reg_id;
                c.data  = cmd_data;
                q.push_back(c);
            end
        end
    end

    // Compare every cycle outside reset against the model.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            checkOutput("beat", 64'(dut_beat), 64'(exp_beat));
            checkOutput("busy", 64'(busy), 64'(in_frame || draining));
            checkOutput("cmd_ready", 64'(cmd_ready), 64'(q.size() < DEPTH));
        end
    end

    // Record the data of every non-null write beat for ordering checks.
    logic [31:0] obs[$];
    initial forever begin
        @(negedge clk);
        if (!rst && program_out && x_out != NULL_ID) begin
            obs.push_back(data_out);
        end
    end

    initial begin
        int          base;
        int          sent;
        int          cycles;
        bit          ready_now;
        bit          stall_checked;

        // Reset and idle
        #1 rst = 1'b1;
        #2;
        checkBeat("reset_beat", 1'b1, NULL_ID, 12'd0, 32'd0, 1'b0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        waitCycles(2);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 11'd0, 12'd0, 32'd0);
        waitCycles(100);
        checkBeat("idle_null", 1'b1, NULL_ID, 12'd0, 32'd0, 1'b0);
        checkOutput("idle_ready", 64'(cmd_ready), 64'd1);

        // Single write while idle
        applyStimulus(1'b0, 1'b1, 11'd3, 12'd4, 32'hFF00_FF00);
        waitCycles(1);
        applyStimulus(1'b0, 1'b0, 11'd0, 12'd0, 32'd0);
        checkBeat("write_latency", 1'b1, NULL_ID, 12'd0, 32'd0, 1'b0);
        waitCycles(1);
        checkBeat("single_write", 1'b1, 11'd3, 12'd4, 32'hFF00_FF00, 1'b0);
        checkOutput("single_busy", 64'(busy), 64'd1);
        waitCycles(1);
        checkBeat("single_null", 1'b1, NULL_ID, 12'd0, 32'd0, 1'b0);
        checkOutput("single_idle", 64'(busy), 64'd0);

        // Frame scan with back-to-back restart
        applyStimulus(1'b1, 1'b0, 11'd0, 12'd0, 32'd0);
        waitCycles(1);
        checkBeat("scan_first", 1'b0, 11'd0, 12'd0, BG, 1'b0);
        waitCycles(31);
        checkBeat("scan_last", 1'b0, 11'd7, 12'd3, BG, 1'b1);
        waitCycles(1);
        checkBeat("scan_restart", 1'b0, 11'd0, 12'd0, BG, 1'b0);
        run = 1'b0;
        waitCycles(40);

        // Deferred writes pushed mid-frame, including reserved shape id
        applyStimulus(1'b1, 1'b0, 11'd0, 12'd0, 32'd0);
        waitCycles(11);
        checkBeat("defer_pixel21", 1'b0, 11'd2, 12'd1, BG, 1'b0);
        applyStimulus(1'b1, 1'b1, 11'd10, 12'd0, 32'h0000_0111);
        waitCycles(1);
        applyStimulus(1'b1, 1'b1, 11'h7FF, 12'hFFF, 32'h1234_5678);
        waitCycles(1);
        applyStimulus(1'b1, 1'b1, 11'd12, 12'd2, 32'h0000_0333);
        waitCycles(1);
        applyStimulus(1'b1, 1'b0, 11'd0, 12'd0, 32'd0);
        waitCycles(18);
        checkBeat("defer_last", 1'b0, 11'd7, 12'd3, BG, 1'b1);
        waitCycles(1);
        checkBeat("defer_w0", 1'b1, 11'd10, 12'd0, 32'h0000_0111, 1'b0);
        waitCycles(1);
        checkBeat("defer_w1", 1'b1, 11'h7FF, 12'hFFF, 32'h1234_5678, 1'b0);
        waitCycles(1);
        checkBeat("defer_w2", 1'b1, 11'd12, 12'd2, 32'h0000_0333, 1'b0);
        waitCycles(1);
        checkBeat("defer_null", 1'b1, NULL_ID, 12'd0, 32'd0, 1'b0);
        waitCycles(1);
        checkBeat("defer_next", 1'b0, 11'd0, 12'd0, BG, 1'b0);
        run = 1'b0;
        waitCycles(40);

        // FIFO full during scan: 10 pushes, 8 fit
        base = obs.size();
        applyStimulus(1'b1, 1'b0, 11'd0, 12'd0, 32'd0);
        waitCycles(1);
        run           = 1'b0;
        sent          = 0;
        cycles        = 0;
        stall_checked = 1'b0;
        while (sent < 10 && cycles < 200) begin
            applyStimulus(1'b0, 1'b1, 11'd5, 12'(sent % 5), 32'hC000_0000 + sent);
            ready_now = cmd_ready;
            if (sent == 8 && !stall_checked) begin
                checkOutput("full_ready", 64'(cmd_ready), 64'd0);
                stall_checked = 1'b1;
            end
            waitCycles(1);
            cycles++;
            if (ready_now) sent++;
        end
        cmd_valid = 1'b0;
        checkOutput("push_budget", 64'(sent), 64'd10);
        waitCycles(15);
        checkOutput("full_count", 64'(obs.size() - base), 64'd10);
        for (int i = 0; i < 10; i++) begin
            if (base + i < obs.size()) begin
                checkOutput($sformatf("full_order%0d", i), 64'(obs[base + i]), 64'(32'hC000_0000 + i));
            end
        end

        // Async reset mid-frame with queued commands
        base = obs.size();
        applyStimulus(1'b1, 1'b0, 11'd0, 12'd0, 32'd0);
        waitCycles(2);
        applyStimulus(1'b1, 1'b1, 11'd20, 12'd1, 32'hDEAD_0001);
        waitCycles(1);
        applyStimulus(1'b1, 1'b1, 11'd21, 12'd2, 32'hDEAD_0002);
        waitCycles(1);
        applyStimulus(1'b1, 1'b0, 11'd0, 12'd0, 32'd0);
        waitCycles(18);
        checkBeat("rst_pixel", 1'b0, 11'd5, 12'd2, BG, 1'b0);
        #2 rst = 1'b1;
        #1;
        checkBeat("rst_null", 1'b1, NULL_ID, 12'd0, 32'd0, 1'b0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_ready", 64'(cmd_ready), 64'd1);
        waitCycles(2);
        rst = 1'b0;
        waitCycles(1);
        checkBeat("rst_restart", 1'b0, 11'd0, 12'd0, BG, 1'b0);
        run = 1'b0;
        waitCycles(40);
        checkOutput("rst_no_stale", 64'(obs.size() - base), 64'd0);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
